// File: rtl/extio_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : extio_pkg
//  Description : Shared constants for the external I/O responder: register
//                addresses, STATUS bit positions, RAM window, and a helper
//                that saturates the FIFO count into the 4-bit STATUS field.
//  Revision    : 1.0 - initial release
// ============================================================================
package extio_pkg;

    // Register addresses on the external bus
    localparam logic [15:0] ADDR_FIFO    = 16'h0100;
    localparam logic [15:0] ADDR_STATUS  = 16'h0101;
    localparam logic [15:0] ADDR_TRELOAD = 16'h0102;
    localparam logic [15:0] ADDR_OUT     = 16'h0103;

    // STATUS register bit positions
    localparam int STAT_EMPTY   = 0;
    localparam int STAT_FULL    = 1;
    localparam int STAT_IRQ     = 2;
    localparam int STAT_CNT_LSB = 4;

    // Scratch RAM window, starting at address zero
    localparam logic [15:0] RAM_BASE = 16'h0000;
    localparam int          RAM_SIZE = 256;

    // Counts above 15 (only possible with a 16-deep FIFO) clip to 15
    function automatic logic [3:0] sat_count4(input logic [4:0] cnt);
        return (cnt > 5'd15) ? 4'hF : cnt[3:0];
    endfunction

endpackage
`default_nettype wire

// File: rtl/extio_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : extio_fifo
//  Description : Synchronous FIFO with push/pop, full/empty flags and count.
//                Push is ignored while full and pop is ignored while empty,
//                so callers may present raw requests.
//  Ports       : clk, rst      - clock, synchronous active-high reset
//                i_push/i_data - enqueue request and word
//                i_pop         - dequeue request
//                o_data        - head entry (valid when !o_empty)
//                o_full/o_empty/o_count - occupancy
//  Revision    : 1.0 - initial release
// ============================================================================
module extio_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       i_push,
    input  logic [WIDTH-1:0]           i_data,
    input  logic                       i_pop,
    output logic [WIDTH-1:0]           o_data,
    output logic                       o_full,
    output logic                       o_empty,
    output logic [$clog2(DEPTH):0]     o_count
);

    localparam int c_AW = $clog2(DEPTH);
    localparam int c_CW = c_AW + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [c_AW-1:0]  r_wr_ptr;
    logic [c_AW-1:0]  r_rd_ptr;
    logic [c_CW-1:0]  r_count;

    logic w_push;
    logic w_pop;

    assign o_full  = (r_count == c_CW'(DEPTH));
    assign o_empty = (r_count == '0);
    assign o_count = r_count;
    assign o_data  = r_mem[r_rd_ptr];

    // Full blocks a push even when a pop happens in the same cycle
    assign w_push = i_push && !o_full;
    assign w_pop  = i_pop  && !o_empty;

    // Storage carries no reset; only pointers and count define validity
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    // DEPTH is a power of two, so pointers wrap naturally
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_AW'(1);
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + c_CW'(1);
            end else if (w_pop && !w_push) begin
                r_count <= r_count - c_CW'(1);
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/ext_io_responder.sv
`default_nettype none
// ============================================================================
//  Module      : ext_io_responder
//  Description : Target-side responder on the CPU external data bus. Decodes
//                dir_mem_ex / wed_ext, drives data_bus on reads of mapped
//                addresses and captures it on writes. Provides a scratch RAM,
//                an input FIFO, an optional reload timer and an output latch.
//  Config      : EXTIO_TIMER_EN - when defined, the timer, TIMER_RELOAD
//                register (0x0102) and timer_irq exist; otherwise 0x0102 is
//                unmapped and timer_irq is tied low.
//  Ports       : clk, reset      - clock, synchronous active-high reset
//                dir_mem_ex      - 16-bit external address
//                wed_ext         - write strobe (CPU drives data_bus)
//                re_ext          - read strobe, qualifies read side effects
//                data_bus        - shared bidirectional data bus
//                in_data/in_valid/in_ready - peripheral push handshake
//                out_port        - output latch
//                timer_irq       - sticky timer-expired flag
//  Revision    : 1.0 - initial release
// ============================================================================
module ext_io_responder
    import extio_pkg::*;
#(
    parameter int FIFO_DEPTH = 4,
    parameter int RAM_WORDS  = RAM_SIZE
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] dir_mem_ex,
    input  logic        wed_ext,
    input  logic        re_ext,
    inout  wire  [15:0] data_bus,
    input  logic [15:0] in_data,
    input  logic        in_valid,
    output logic        in_ready,
    output logic [15:0] out_port,
    output logic        timer_irq
);

    localparam int          c_RAM_AW    = $clog2(RAM_WORDS);
    localparam int          c_CW        = $clog2(FIFO_DEPTH) + 1;
    localparam logic [16:0] c_RAM_LIMIT = 17'(RAM_WORDS);

    // ------------------------------------------------------------------
    // Address decode
    // ------------------------------------------------------------------
    logic w_ram_sel;
    logic w_fifo_sel;
    logic w_stat_sel;
    logic w_trl_sel;
    logic w_out_sel;
    logic w_mapped;

    assign w_ram_sel  = ({1'b0, dir_mem_ex} < c_RAM_LIMIT);
    assign w_fifo_sel = (dir_mem_ex == ADDR_FIFO);
    assign w_stat_sel = (dir_mem_ex == ADDR_STATUS);
    assign w_out_sel  = (dir_mem_ex == ADDR_OUT);
`ifdef EXTIO_TIMER_EN
    assign w_trl_sel  = (dir_mem_ex == ADDR_TRELOAD);
`else
    assign w_trl_sel  = 1'b0;
`endif
    assign w_mapped   = w_ram_sel | w_fifo_sel | w_stat_sel | w_trl_sel | w_out_sel;

    // ------------------------------------------------------------------
    // Scratch RAM: synchronous write, combinational read, never reset
    // ------------------------------------------------------------------
    logic [15:0]         r_ram [RAM_WORDS];
    logic [c_RAM_AW-1:0] w_ram_idx;

    assign w_ram_idx = dir_mem_ex[c_RAM_AW-1:0];

    always_ff @(posedge clk) begin
        if (wed_ext && w_ram_sel) begin
            r_ram[w_ram_idx] <= data_bus;
        end
    end

    // ------------------------------------------------------------------
    // Input FIFO
    // ------------------------------------------------------------------
    logic [15:0]     w_fifo_head;
    logic            w_fifo_full;
    logic            w_fifo_empty;
    logic [c_CW-1:0] w_fifo_count;
    logic            w_pop;

    // Read side effects need the read strobe, not just an address match
    assign w_pop    = re_ext && !wed_ext && w_fifo_sel;
    assign in_ready = !w_fifo_full;

    extio_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (16)
    ) u_fifo (
        .clk     (clk),
        .rst     (reset),
        .i_push  (in_valid),
        .i_data  (in_data),
        .i_pop   (w_pop),
        .o_data  (w_fifo_head),
        .o_full  (w_fifo_full),
        .o_empty (w_fifo_empty),
        .o_count (w_fifo_count)
    );

    // ------------------------------------------------------------------
    // Reload timer
    // ------------------------------------------------------------------
`ifdef EXTIO_TIMER_EN
    logic [15:0] r_reload;
    logic [15:0] r_tcount;
    logic        r_irq;
    logic        w_trl_wr;
    logic        w_expire;
    logic        w_irq_clr;

    assign w_trl_wr  = wed_ext && w_trl_sel;
    // A reload write restarts the count, so it suppresses expiry that cycle
    assign w_expire  = (r_tcount == 16'd1) && !w_trl_wr;
    assign w_irq_clr = re_ext && !wed_ext && w_stat_sel;
    assign timer_irq = r_irq;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_reload <= 16'd0;
            r_tcount <= 16'd0;
            r_irq    <= 1'b0;
        end else begin
            if (w_trl_wr) begin
                r_reload <= data_bus;
                r_tcount <= data_bus;
            end else if (w_expire) begin
                r_tcount <= r_reload;
            end else if (r_tcount != 16'd0) begin
                r_tcount <= r_tcount - 16'd1;
            end

            // Expiry in the same cycle as a STATUS read keeps the flag set
            if (w_expire) begin
                r_irq <= 1'b1;
            end else if (w_irq_clr) begin
                r_irq <= 1'b0;
            end
        end
    end
`else
    assign timer_irq = 1'b0;
`endif

    // ------------------------------------------------------------------
    // Output latch
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            out_port <= 16'h0000;
        end else if (wed_ext && w_out_sel) begin
            out_port <= data_bus;
        end
    end

    // ------------------------------------------------------------------
    // Read mux and bus drive
    // ------------------------------------------------------------------
    logic [15:0] w_status;
    logic [15:0] w_rd_data;

    always_comb begin
        w_status                            = 16'h0000;
        w_status[STAT_EMPTY]                = w_fifo_empty;
        w_status[STAT_FULL]                 = w_fifo_full;
        w_status[STAT_IRQ]                  = timer_irq;
        w_status[STAT_CNT_LSB +: 4]         = sat_count4(5'(w_fifo_count));
    end

    always_comb begin
        w_rd_data = 16'h0000;
        if (w_ram_sel) begin
            w_rd_data = r_ram[w_ram_idx];
        end else if (w_fifo_sel) begin
            w_rd_data = w_fifo_empty ? 16'h0000 : w_fifo_head;
        end else if (w_stat_sel) begin
            w_rd_data = w_status;
`ifdef EXTIO_TIMER_EN
        end else if (w_trl_sel) begin
            w_rd_data = r_reload;
`endif
        end else if (w_out_sel) begin
            w_rd_data = out_port;
        end
    end

    assign data_bus = (w_mapped && !wed_ext) ? w_rd_data : 16'bz;

endmodule
`default_nettype wire

// File: tb/tb_ext_io_responder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ext_io_responder
//  Description : Directed self-checking bench for ext_io_responder. The bus
//                carries a pull-up so an undriven bus reads 0xFFFF.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_ext_io_responder;

    logic        clk;
    logic        reset;
    logic [15:0] dir_mem_ex;
    logic        wed_ext;
    logic        re_ext;
    tri1  [15:0] data_bus;
    logic [15:0] in_data;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] out_port;
    logic        timer_irq;

    logic        r_drv_en;
    logic [15:0] r_drv_data;

    int n_vec;
    int n_err;

    localparam logic [15:0] c_HIZ = 16'hFFFF;

    assign data_bus = r_drv_en ? r_drv_data : 16'bz;

    ext_io_responder #(
        .FIFO_DEPTH (4),
        .RAM_WORDS  (256)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .dir_mem_ex (dir_mem_ex),
        .wed_ext    (wed_ext),
        .re_ext     (re_ext),
        .data_bus   (data_bus),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .out_port   (out_port),
        .timer_irq  (timer_irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%04h, expected 0x%04h", tag, got, exp);
        end
    endtask

    // Called just after a rising edge; returns just after the next one
    task automatic bus_write(input logic [15:0] addr, input logic [15:0] data);
        dir_mem_ex = addr;
        r_drv_data = data;
        r_drv_en   = 1'b1;
        wed_ext    = 1'b1;
        @(posedge clk);
        #1;
        wed_ext    = 1'b0;
        r_drv_en   = 1'b0;
    endtask

    task automatic bus_read(input logic [15:0] addr, input logic re, output logic [15:0] data);
        dir_mem_ex = addr;
        wed_ext    = 1'b0;
        re_ext     = re;
        #1;
        data = data_bus;
        @(posedge clk);
        #1;
        re_ext = 1'b0;
    endtask

    task automatic push_word(input logic [15:0] data);
        in_data  = data;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    logic [15:0] rd;

    initial begin
        n_vec      = 0;
        n_err      = 0;
        reset      = 1'b1;
        dir_mem_ex = 16'h0000;
        wed_ext    = 1'b0;
        re_ext     = 1'b0;
        in_data    = 16'h0000;
        in_valid   = 1'b0;
        r_drv_en   = 1'b0;
        r_drv_data = 16'h0000;

        repeat (2) @(posedge clk);
        #1;
        check("rst_in_ready", {15'd0, in_ready}, 16'h0001);
        check("rst_out_port", out_port, 16'h0000);
        check("rst_irq", {15'd0, timer_irq}, 16'h0000);
        reset = 1'b0;
        bus_read(16'h0101, 1'b0, rd);
        check("rst_status", rd, 16'h0001);

        // ---------------- RAM ----------------
        bus_write(16'h0000, 16'h0000);
        bus_write(16'h0010, 16'hBEEF);
        bus_write(16'h00FF, 16'h1234);
        bus_read(16'h0010, 1'b1, rd);
        check("ram_10", rd, 16'hBEEF);
        bus_read(16'h00FF, 1'b0, rd);
        check("ram_ff", rd, 16'h1234);
        bus_read(16'h0200, 1'b1, rd);
        check("unmapped_200", rd, c_HIZ);
        bus_read(16'h0104, 1'b1, rd);
        check("unmapped_104", rd, c_HIZ);

        // Writes to STATUS / FIFO data are ignored
        bus_write(16'h0101, 16'hFFFF);
        bus_write(16'h0100, 16'h5555);
        bus_read(16'h0101, 1'b0, rd);
        check("status_ro", rd, 16'h0001);

        // ---------------- FIFO ----------------
        for (int k = 1; k <= 4; k++) push_word(16'(k));
        check("full_in_ready", {15'd0, in_ready}, 16'h0000);
        bus_read(16'h0101, 1'b0, rd);
        check("full_status", rd, 16'h0042);
        for (int k = 1; k <= 4; k++) begin
            bus_read(16'h0100, 1'b1, rd);
            check("pop_order", rd, 16'(k));
        end
        bus_read(16'h0100, 1'b1, rd);
        check("pop_empty", rd, 16'h0000);
        bus_read(16'h0101, 1'b0, rd);
        check("empty_status", rd, 16'h0001);

        // Full FIFO: simultaneous offer and pop must not accept the offer
        for (int k = 1; k <= 4; k++) push_word(16'h0010 + 16'(k));
        in_data    = 16'h0099;
        in_valid   = 1'b1;
        dir_mem_ex = 16'h0100;
        re_ext     = 1'b1;
        #1;
        check("full_pop_ready", {15'd0, in_ready}, 16'h0000);
        check("full_pop_data", data_bus, 16'h0011);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        re_ext   = 1'b0;
        bus_read(16'h0101, 1'b0, rd);
        check("count3_status", rd, 16'h0030);
        for (int k = 2; k <= 4; k++) begin
            bus_read(16'h0100, 1'b1, rd);
            check("drain", rd, 16'h0010 + 16'(k));
        end
        bus_read(16'h0101, 1'b0, rd);
        check("drained_status", rd, 16'h0001);

        // ---------------- OUT_PORT ----------------
        bus_write(16'h0103, 16'h00A5);
        check("out_port", out_port, 16'h00A5);
        bus_read(16'h0103, 1'b1, rd);
        check("out_read", rd, 16'h00A5);

`ifdef EXTIO_TIMER_EN
        // ---------------- Timer ----------------
        bus_write(16'h0102, 16'h0005);
        repeat (4) @(posedge clk);
        #1;
        check("irq_early", {15'd0, timer_irq}, 16'h0000);
        @(posedge clk);
        #1;
        check("irq_rise1", {15'd0, timer_irq}, 16'h0001);
        bus_read(16'h0101, 1'b1, rd);
        check("irq_status", rd, 16'h0005);
        check("irq_cleared", {15'd0, timer_irq}, 16'h0000);
        repeat (3) @(posedge clk);
        #1;
        check("irq_early2", {15'd0, timer_irq}, 16'h0000);
        @(posedge clk);
        #1;
        check("irq_rise2", {15'd0, timer_irq}, 16'h0001);
        bus_read(16'h0102, 1'b0, rd);
        check("reload_read", rd, 16'h0005);

        bus_write(16'h0102, 16'h0000);
        bus_read(16'h0101, 1'b1, rd);
        repeat (20) @(posedge clk);
        #1;
        check("irq_disabled", {15'd0, timer_irq}, 16'h0000);

        bus_write(16'h0102, 16'h0003);
        repeat (3) @(posedge clk);
        #1;
        check("irq_rise3", {15'd0, timer_irq}, 16'h0001);
`else
        // ---------------- Timer absent ----------------
        bus_write(16'h0102, 16'h1234);
        bus_read(16'h0102, 1'b1, rd);
        check("treload_unmapped", rd, c_HIZ);
        repeat (5) @(posedge clk);
        #1;
        check("irq_tied", {15'd0, timer_irq}, 16'h0000);
`endif

        // ---------------- Reset mid-activity ----------------
        push_word(16'h0042);
        reset    = 1'b1;
        in_data  = 16'h0077;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        check("rst2_out_port", out_port, 16'h0000);
        check("rst2_in_ready", {15'd0, in_ready}, 16'h0001);
        check("rst2_irq", {15'd0, timer_irq}, 16'h0000);
        reset    = 1'b0;
        in_valid = 1'b0;
        bus_read(16'h0101, 1'b0, rd);
        check("rst2_status", rd, 16'h0001);
        bus_read(16'h0100, 1'b1, rd);
        check("rst2_fifo", rd, 16'h0000);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/ext_io_responder.md
# ext_io_responder

Target-side responder for the CPU's external data bus. It decodes the 16-bit external address and the external write strobe, drives the shared bidirectional data bus on reads and captures it on writes. Behind the bus it provides:
- a 256-word scratch RAM,
- a handshaked input FIFO fed by a peripheral source,
- a free-running reload timer,
- a 16-bit output latch.

It sits outside the CPU datapath and connects directly to the address, write-enable and data-bus pins the datapath exposes.

## Interface
Parameters:
- FIFO_DEPTH, 4, input FIFO entries; power of two, 2..16
- RAM_WORDS, 256, scratch RAM words; power of two, ≤256

Ports:
- clk  in  1  system clock, all state on rising edge
- reset  in  1  synchronous, active-high
- dir_mem_ex  in  16  external address from CPU
- wed_ext  in  1  CPU write strobe; CPU drives data_bus while high
- re_ext  in  1  CPU read strobe; qualifies read side effects only
- data_bus  inout  16  shared data bus
- in_data  in  16  peripheral word to enqueue
- in_valid  in  1  peripheral offers in_data
- in_ready  out  1  FIFO can accept; equals !full
- out_port  out  16  output latch contents
- timer_irq  out  1  sticky timer-expired flag

## Operation
- Address map:
  - 0x0000..RAM_WORDS-1: RAM
  - 0x0100: FIFO data (read = pop)
  - 0x0101: STATUS (read-only)
  - 0x0102: TIMER_RELOAD (read/write)
  - 0x0103: OUT_PORT (read/write)
  - All other addresses are unmapped.
- Bus drive: data_bus = selected read value when a mapped address is selected and wed_ext=0; otherwise high-Z. Unmapped addresses are never driven. wed_ext=1 always forces high-Z.
- RAM: write when wed_ext=1 with a RAM address. Read is combinational.
- FIFO:
  - Push when in_valid && in_ready.
  - Pop when re_ext=1, wed_ext=0, addr=0x0100 and the FIFO is non-empty.
  - Read value is the head entry, or 0x0000 when empty; a pop on empty changes no state.
  - Simultaneous push and pop when neither full nor empty: count unchanged, both pointers advance.
  - When full, in_ready=0 even if a pop occurs in the same cycle.
  - Pointers wrap modulo FIFO_DEPTH.
- STATUS: bit0 empty, bit1 full, bit2 timer_irq, bits[7:4] count (saturating), other bits 0. A read with re_ext=1 clears timer_irq at the edge. If expiry occurs in the same cycle, the set wins.
- Timer: 16-bit down counter.
  - Writing TIMER_RELOAD loads the reload register and the counter.
  - Reload value 0 disables the timer: counter holds at 0, no expiry.
  - Otherwise the counter decrements each cycle. On reaching 1 it reloads on the next edge and sets timer_irq.
- Writes to STATUS and FIFO data are ignored. Writes to unmapped addresses are ignored.

## Timing
- Reads: combinational, same cycle. The CPU samples data_bus before the edge. Side effects (pop, irq clear) take effect at that edge.
- Writes: take effect at the rising edge; readable the next cycle.
- in_ready is combinational from registered state only.
- Expiry: with reload N≥1, timer_irq rises exactly N cycles after the edge that loaded N, and every N cycles thereafter.
- Reset values (synchronous, dominates all other activity that cycle):
  - FIFO empty, in_ready=1
  - out_port=0x0000
  - reload=0, counter=0, timer_irq=0
  - RAM contents undefined, not reset
- Reset mid-transfer discards FIFO contents; a push offered in the reset cycle is dropped.

## Configuration
- EXTIO_TIMER_EN defined: timer, TIMER_RELOAD register and timer_irq are implemented as above.
- Not defined:
  - Timer logic is absent.
  - timer_irq is tied to 0 and STATUS bit2 reads 0.
  - 0x0102 is treated as unmapped: not driven, writes ignored.

## Structure
- Shared package `extio_pkg`:
  - address constants ADDR_FIFO, ADDR_STATUS, ADDR_TRELOAD, ADDR_OUT
  - STATUS bit indices
  - RAM base/size
- Sub-module `extio_fifo`: parameterised synchronous FIFO with push/pop/full/empty/count.
- The top level holds the decode, bus drive, RAM, timer and output latch.

## Test plan
- RAM: write 0xBEEF to 0x0010, read 0x0010 next cycle → data_bus=0xBEEF. Read 0x0200 → data_bus high-Z.
- FIFO: push 0x0001..0x0004 → in_ready=0, STATUS=0x0042. Four pops return 1,2,3,4 in order; a fifth pop → 0x0000, STATUS=0x0001.
- Full FIFO: in_valid=1 with a simultaneous pop → that cycle's in_data is not accepted, count=3 after the edge.
- Timer: write reload 5 → timer_irq rises 5 cycles later. STATUS read with re_ext → irq clears; it rises again after 5 more cycles. Reload 0 → never rises.
- OUT_PORT: write 0x00A5 → out_port=0x00A5 after the edge. Assert reset → out_port=0, FIFO empty, timer_irq=0 on the same edge.
- Build without EXTIO_TIMER_EN: write 0x0102 then read it → bus high-Z, timer_irq stays 0.
